// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - dual-lane retire record FIFO presenting one record per beat in program order
module commit_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [1:0]                   commit_valid_i,
  output logic                         commit_ready_o,
  input  logic [2*XLEN-1:0]            commit_pc_i,
  input  logic [2*XLEN-1:0]            commit_instr_i,
  input  logic [9:0]                   commit_reg_addr_i,
  input  logic [2*XLEN-1:0]            commit_reg_data_i,
  input  logic [1:0]                   commit_mem_wrt_i,
  input  logic [2*XLEN-1:0]            commit_mem_addr_i,
  input  logic [2*XLEN-1:0]            commit_mem_data_i,
  output logic                         trace_valid_o,
  input  logic                         trace_ready_i,
  output logic [XLEN-1:0]              trace_pc_o,
  output logic [XLEN-1:0]              trace_instr_o,
  output logic [4:0]                   trace_reg_addr_o,
  output logic [XLEN-1:0]              trace_reg_data_o,
  output logic                         trace_mem_wrt_o,
  output logic [XLEN-1:0]              trace_mem_addr_o,
  output logic [XLEN-1:0]              trace_mem_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            lane_rec [2];
  rec_t            first_rec;
  rec_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wr_ptr_inc;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            overflow;
  logic            push;
  logic            pop;
  logic            dual;
  logic            nonempty;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lane_rec[l].pc       = commit_pc_i[l*XLEN +: XLEN];
      lane_rec[l].instr    = commit_instr_i[l*XLEN +: XLEN];
      lane_rec[l].reg_addr = commit_reg_addr_i[l*5 +: 5];
      lane_rec[l].reg_data = commit_reg_data_i[l*XLEN +: XLEN];
      lane_rec[l].mem_wrt  = commit_mem_wrt_i[l];
      lane_rec[l].mem_addr = commit_mem_addr_i[l*XLEN +: XLEN];
      lane_rec[l].mem_data = commit_mem_data_i[l*XLEN +: XLEN];
    end
  end

  // Ready looks only at the registered count, so a same-cycle pop never makes room.
  assign commit_ready_o = (count <= CW'(DEPTH - 2));
  assign nonempty       = (count != '0);
  assign push           = commit_ready_o && (commit_valid_i != 2'b00);
  assign dual           = &commit_valid_i;
  assign pop            = nonempty && trace_ready_i;
  assign wr_ptr_inc     = wr_ptr + PW'(1);

  // A lone lane-1 retire lands at wr_ptr like any single record, leaving no hole.
  assign first_rec = commit_valid_i[0] ? lane_rec[0] : lane_rec[1];

  always_comb begin
    count_next = count;
    if (push) begin
      count_next = count_next + (dual ? CW'(2) : CW'(1));
    end
    if (pop) begin
      count_next = count_next - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= first_rec;
      if (dual) begin
        mem[wr_ptr_inc] <= lane_rec[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= dual ? wr_ptr + PW'(2) : wr_ptr_inc;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
      if ((commit_valid_i != 2'b00) && !commit_ready_o) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

  // Fields that carry no meaning for the head record are zeroed for the logger.
  assign trace_valid_o    = nonempty;
  assign trace_pc_o       = nonempty ? head.pc : '0;
  assign trace_instr_o    = nonempty ? head.instr : '0;
  assign trace_reg_addr_o = nonempty ? head.reg_addr : '0;
  assign trace_reg_data_o = (nonempty && head.reg_addr != 5'd0) ? head.reg_data : '0;
  assign trace_mem_wrt_o  = nonempty && head.mem_wrt;
  assign trace_mem_addr_o = (nonempty && head.mem_wrt) ? head.mem_addr : '0;
  assign trace_mem_data_o = (nonempty && head.mem_wrt) ? head.mem_data : '0;
  assign count_o          = count;
  assign overflow_o       = overflow;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - scoreboard bench for commit_trace_fifo
module tb_commit_trace_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  logic              clk_i;
  logic              rstn_i;
  logic [1:0]        commit_valid_i;
  logic              commit_ready_o;
  logic [2*XLEN-1:0] commit_pc_i;
  logic [2*XLEN-1:0] commit_instr_i;
  logic [9:0]        commit_reg_addr_i;
  logic [2*XLEN-1:0] commit_reg_data_i;
  logic [1:0]        commit_mem_wrt_i;
  logic [2*XLEN-1:0] commit_mem_addr_i;
  logic [2*XLEN-1:0] commit_mem_data_i;
  logic              trace_valid_o;
  logic              trace_ready_i;
  logic [XLEN-1:0]   trace_pc_o;
  logic [XLEN-1:0]   trace_instr_o;
  logic [4:0]        trace_reg_addr_o;
  logic [XLEN-1:0]   trace_reg_data_o;
  logic              trace_mem_wrt_o;
  logic [XLEN-1:0]   trace_mem_addr_o;
  logic [XLEN-1:0]   trace_mem_data_o;
  logic [3:0]        count_o;
  logic              overflow_o;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];

  commit_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
    .commit_reg_addr_i(commit_reg_addr_i), .commit_reg_data_i(commit_reg_data_i),
    .commit_mem_wrt_i(commit_mem_wrt_i), .commit_mem_addr_i(commit_mem_addr_i),
    .commit_mem_data_i(commit_mem_data_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_reg_addr_o(trace_reg_addr_o), .trace_reg_data_o(trace_reg_data_o),
    .trace_mem_wrt_o(trace_mem_wrt_o), .trace_mem_addr_o(trace_mem_addr_o),
    .trace_mem_data_o(trace_mem_data_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic [31:0] rdata,
                              input logic mw, input logic [31:0] ma, input logic [31:0] md);
    rec_t r;
    r.pc = pc; r.instr = instr; r.reg_addr = rd; r.reg_data = rdata;
    r.mem_wrt = mw; r.mem_addr = ma; r.mem_data = md;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input rec_t l0, input rec_t l1);
    commit_valid_i    = v;
    commit_pc_i       = {l1.pc, l0.pc};
    commit_instr_i    = {l1.instr, l0.instr};
    commit_reg_addr_i = {l1.reg_addr, l0.reg_addr};
    commit_reg_data_i = {l1.reg_data, l0.reg_data};
    commit_mem_wrt_i  = {l1.mem_wrt, l0.mem_wrt};
    commit_mem_addr_i = {l1.mem_addr, l0.mem_addr};
    commit_mem_data_i = {l1.mem_data, l0.mem_data};
    tick();
    commit_valid_i = 2'b00;
  endtask

  task automatic drain(input string name);
    int n;
    trace_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || trace_valid_o) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      errors++;
      checks++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
    end
    chk({name, "_count_after_drain"}, 64'(count_o), 64'd0);
  endtask

  // Monitor: the beat visible at the falling edge is the one the next rising edge pops.
  always @(negedge clk_i) begin
    rec_t got;
    rec_t e;
    if (rstn_i && trace_valid_o && trace_ready_i) begin
      got = mk(trace_pc_o, trace_instr_o, trace_reg_addr_o, trace_reg_data_o,
               trace_mem_wrt_o, trace_mem_addr_o, trace_mem_data_o);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got pc=%h expected no beat", got.pc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got pc=%h ins=%h rd=%0d rdat=%h mw=%b ma=%h md=%h expected pc=%h ins=%h rd=%0d rdat=%h mw=%b ma=%h md=%h",
                   got.pc, got.instr, got.reg_addr, got.reg_data, got.mem_wrt, got.mem_addr, got.mem_data,
                   e.pc, e.instr, e.reg_addr, e.reg_data, e.mem_wrt, e.mem_addr, e.mem_data);
        end
      end
    end
  end

  rec_t z;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b0;
    trace_ready_i = 1'b0;
    commit_valid_i = 2'b00;
    commit_pc_i = '0; commit_instr_i = '0; commit_reg_addr_i = '0; commit_reg_data_i = '0;
    commit_mem_wrt_i = '0; commit_mem_addr_i = '0; commit_mem_data_i = '0;
    tick();
    tick();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_pc", 64'(trace_pc_o), 64'd0);
    rstn_i = 1'b1;
    #1;
    chk("ready_after_release", 64'(commit_ready_o), 64'd1);

    // Single lane-0 commit, consumer always ready; mem fields forced to 0.
    trace_ready_i = 1'b1;
    exp_q.push_back(mk(32'h80000000, 32'h00500093, 5'd1, 32'h5, 1'b0, 32'h0, 32'h0));
    drive(2'b01, mk(32'h80000000, 32'h00500093, 5'd1, 32'h5, 1'b0, 32'hAAAA, 32'hBBBB), z);
    chk("t1_valid_after_push", 64'(trace_valid_o), 64'd1);
    tick();
    chk("t1_valid_one_cycle", 64'(trace_valid_o), 64'd0);
    chk("t1_count", 64'(count_o), 64'd0);

    // Dual commit with stalled consumer: store with rd=0, then register write.
    trace_ready_i = 1'b0;
    exp_q.push_back(mk(32'h80000004, 32'h0062a023, 5'd0, 32'h0, 1'b1, 32'h100, 32'hDEADBEEF));
    exp_q.push_back(mk(32'h80000008, 32'h00700113, 5'd2, 32'h7, 1'b0, 32'h0, 32'h0));
    drive(2'b11, mk(32'h80000004, 32'h0062a023, 5'd0, 32'h1111, 1'b1, 32'h100, 32'hDEADBEEF),
                 mk(32'h80000008, 32'h00700113, 5'd2, 32'h7, 1'b0, 32'h55, 32'h66));
    tick();
    tick();
    chk("t2_count", 64'(count_o), 64'd2);
    chk("t2_head_pc", 64'(trace_pc_o), 64'h80000004);
    chk("t2_head_reg_data_forced", 64'(trace_reg_data_o), 64'd0);
    drain("t2");

    // Fill to DEPTH with dual commits, then one dropped commit.
    trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(32'h1000 + 32'(8*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
      exp_q.push_back(mk(32'h1004 + 32'(8*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
      drive(2'b11, mk(32'h1000 + 32'(8*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0),
                   mk(32'h1004 + 32'(8*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
      chk("t3_fill_count", 64'(count_o), 64'(2*(i+1)));
      chk("t3_fill_ready", 64'(commit_ready_o), (i < 3) ? 64'd1 : 64'd0);
    end
    chk("t3_no_overflow_yet", 64'(overflow_o), 64'd0);
    drive(2'b11, mk(32'h2000, 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0),
                 mk(32'h2004, 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
    chk("t3_overflow", 64'(overflow_o), 64'd1);
    chk("t3_count_held", 64'(count_o), 64'd8);
    drain("t3");

    // Wrap: four singles move wr_ptr from 3 to 7, then a straddling dual push.
    trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(32'h400 + 32'(4*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
      drive(2'b01, mk(32'h400 + 32'(4*i), 32'h13, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0), z);
    end
    tick();
    trace_ready_i = 1'b0;
    exp_q.push_back(mk(32'h200, 32'h13, 5'd3, 32'h33, 1'b0, 32'h0, 32'h0));
    exp_q.push_back(mk(32'h204, 32'h13, 5'd4, 32'h44, 1'b0, 32'h0, 32'h0));
    drive(2'b11, mk(32'h200, 32'h13, 5'd3, 32'h33, 1'b0, 32'h0, 32'h0),
                 mk(32'h204, 32'h13, 5'd4, 32'h44, 1'b0, 32'h0, 32'h0));
    chk("t4_count", 64'(count_o), 64'd2);
    drain("t4");

    // Lane-1-only commit followed by lane-0-only commit.
    trace_ready_i = 1'b0;
    exp_q.push_back(mk(32'h300, 32'h13, 5'd5, 32'h500, 1'b0, 32'h0, 32'h0));
    exp_q.push_back(mk(32'h304, 32'h13, 5'd0, 32'h0, 1'b1, 32'h80, 32'h90));
    drive(2'b10, mk(32'hBAD, 32'hBAD, 5'd9, 32'hBAD, 1'b1, 32'hBAD, 32'hBAD),
                 mk(32'h300, 32'h13, 5'd5, 32'h500, 1'b0, 32'h0, 32'h0));
    drive(2'b01, mk(32'h304, 32'h13, 5'd0, 32'h0, 1'b1, 32'h80, 32'h90),
                 mk(32'hBAD, 32'hBAD, 5'd9, 32'hBAD, 1'b1, 32'hBAD, 32'hBAD));
    chk("t5_count", 64'(count_o), 64'd2);
    trace_ready_i = 1'b1;
    tick();
    chk("t5_no_gap_valid", 64'(trace_valid_o), 64'd1);
    chk("t5_no_gap_pc", 64'(trace_pc_o), 64'h304);
    drain("t5");

    // Asynchronous reset with five records buffered.
    trace_ready_i = 1'b0;
    drive(2'b11, mk(32'h600, 32'h13, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0),
                 mk(32'h604, 32'h13, 5'd1, 32'h2, 1'b0, 32'h0, 32'h0));
    drive(2'b11, mk(32'h608, 32'h13, 5'd1, 32'h3, 1'b0, 32'h0, 32'h0),
                 mk(32'h60C, 32'h13, 5'd1, 32'h4, 1'b0, 32'h0, 32'h0));
    drive(2'b01, mk(32'h610, 32'h13, 5'd1, 32'h5, 1'b0, 32'h0, 32'h0), z);
    chk("t6_count_before_reset", 64'(count_o), 64'd5);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_async_valid", 64'(trace_valid_o), 64'd0);
    chk("t6_async_count", 64'(count_o), 64'd0);
    chk("t6_async_overflow", 64'(overflow_o), 64'd0);
    chk("t6_async_pc", 64'(trace_pc_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    trace_ready_i = 1'b1;
    exp_q.push_back(mk(32'h700, 32'h00100093, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0));
    drive(2'b01, mk(32'h700, 32'h00100093, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0), z);
    chk("t6_first_beat_pc", 64'(trace_pc_o), 64'h700);
    drain("t6");

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
